jump_charge: RTL and testbench



---
 rtl/jump_charge_pkg.sv | 17 +
 rtl/jump_charge_btn_debounce.sv | 44 ++++
 rtl/jump_charge.sv | 103 ++++++++++
 tb/tb_jump_charge.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/jump_charge_pkg.sv
// Shared constants for the jump-button charge stage; the game FSM's jump
// scaling also uses JUMP_MAX_DEF.
package jump_charge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CHARGE   = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_e;

   localparam int JUMP_MAX_DEF = 40;

   function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
      return (v >= lim) ? lim : v + 8'd1;
   endfunction

endpackage

// File: rtl/jump_charge_btn_debounce.sv
// Push-button synchroniser plus stable-count debouncer. Also intended for
// the restart button.
module btn_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4
) (
   input  logic clk,
   input  logic restart,
   input  logic btn,
   output logic btn_db
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   db_q;
   logic                   btn_s;

   assign btn_s  = sync_q[SYNC_STAGES-1];
   assign btn_db = db_q;

   always_ff @(posedge clk) begin
      if (restart) begin
         sync_q <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
         // The level flips only after DB_CYCLES consecutive disagreeing samples.
         if (btn_s != db_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
               db_q  <= btn_s;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/jump_charge.sv
// Jump button -> saturating hold-time charge on jump_dist_o, followed by a
// forced-zero cooldown so the game FSM always sees a clean end-of-jump.
module jump_charge
   import jump_charge_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4,
   parameter int RATE_LOG2   = 3,
   parameter int JUMP_MAX    = JUMP_MAX_DEF,
   parameter int COOL_CYCLES = 4
) (
   input  logic       clk,
   input  logic       restart,
   input  logic       btn_i,
   input  logic       enable_i,
   output logic [7:0] jump_dist_o,
   output logic       charging_o,
   output logic       released_o,
   output logic [7:0] last_jump_o
);

   localparam int            HOLD = SYNC_STAGES + DB_CYCLES;
   localparam int            HW   = $clog2(HOLD + 1);
   localparam int            CLW  = $clog2(COOL_CYCLES);
   localparam int            PW   = (RATE_LOG2 > 0) ? RATE_LOG2 : 1;
   localparam logic [PW-1:0] PMAX = PW'((1 << RATE_LOG2) - 1);
   localparam logic [7:0]    JMAX = 8'(JUMP_MAX);

   logic           btn_db;
   state_e         state_q;
   logic [7:0]     jd_q, last_q;
   logic           charging_q, released_q, armed_q, db_prev_q;
   logic [PW-1:0]  presc_q;
   logic [CLW-1:0] cool_q;
   logic [HW-1:0]  hold_q;

   btn_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
   ) u_db (
      .clk     (clk),
      .restart (restart),
      .btn     (btn_i),
      .btn_db  (btn_db)
   );

   always_ff @(posedge clk) begin
      if (restart) begin
         state_q    <= ST_IDLE;
         jd_q       <= '0;
         last_q     <= '0;
         charging_q <= 1'b0;
         released_q <= 1'b0;
         armed_q    <= 1'b0;
         db_prev_q  <= 1'b0;
         presc_q    <= '0;
         cool_q     <= '0;
         hold_q     <= '0;
      end else begin
         db_prev_q  <= btn_db;
         released_q <= 1'b0;
         if (hold_q != HW'(HOLD)) hold_q <= hold_q + HW'(1);
         case (state_q)
            ST_IDLE: begin
               // The debouncer restarts low, so a button held through restart
               // would look released; only arm once the pipeline has refilled.
               if (!btn_db && hold_q == HW'(HOLD)) armed_q <= 1'b1;
               if (armed_q && enable_i && btn_db && !db_prev_q) begin
                  state_q    <= ST_CHARGE;
                  jd_q       <= 8'd1;
                  presc_q    <= '0;
                  charging_q <= 1'b1;
               end
            end
            ST_CHARGE: begin
               if (!btn_db) begin
                  state_q    <= ST_COOLDOWN;
                  jd_q       <= '0;
                  last_q     <= jd_q;
                  released_q <= 1'b1;
                  charging_q <= 1'b0;
                  armed_q    <= 1'b0;
                  cool_q     <= '0;
               end else begin
                  presc_q <= (presc_q == PMAX) ? '0 : presc_q + PW'(1);
                  if (presc_q == PMAX) jd_q <= sat_inc(jd_q, JMAX);
               end
            end
            ST_COOLDOWN: begin
               if (cool_q == CLW'(COOL_CYCLES - 1)) state_q <= ST_IDLE;
               else                                 cool_q  <= cool_q + CLW'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign jump_dist_o = jd_q;
   assign charging_o  = charging_q;
   assign released_o  = released_q;
   assign last_jump_o = last_q;

endmodule

// File: tb/tb_jump_charge.sv
// Directed bench for jump_charge: table of press scenarios with a per-edge
// expected trace, plus hand sequences for cooldown, restart and enable cases.
module tb_jump_charge;

   logic       clk = 1'b0;
   logic       restart, btn_i, enable_i;
   logic [7:0] jump_dist_o, last_jump_o;
   logic       charging_o, released_o;

   int tests = 0;
   int fails = 0;

   jump_charge dut (
      .clk         (clk),
      .restart     (restart),
      .btn_i       (btn_i),
      .enable_i    (enable_i),
      .jump_dist_o (jump_dist_o),
      .charging_o  (charging_o),
      .released_o  (released_o),
      .last_jump_o (last_jump_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      bit en;
      bit chg;
      int last;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      btn_i = 1'b0;
      repeat (n) tick();
   endtask

   // Press for v.len cycles; a started charge shows 1 at edge 7, steps every
   // 8 edges up to 40, and drops with a released pulse at edge len+7.
   task automatic run_vec(input vec_t v, input int idx);
      int         errs;
      int         rel;
      int         tmp;
      logic [7:0] exp_jd;
      logic       exp_ch, exp_rel;
      errs     = 0;
      rel      = v.len + 7;
      enable_i = v.en;
      idle(30);
      btn_i = 1'b1;
      for (int k = 1; k <= v.len + 20; k++) begin
         tick();
         exp_jd  = 8'd0;
         exp_ch  = 1'b0;
         exp_rel = 1'b0;
         if (v.chg) begin
            if (k >= 7 && k < rel) begin
               tmp    = 1 + (k - 7) / 8;
               exp_jd = 8'((tmp > 40) ? 40 : tmp);
               exp_ch = 1'b1;
            end
            if (k == rel) exp_rel = 1'b1;
         end
         if (jump_dist_o !== exp_jd || charging_o !== exp_ch || released_o !== exp_rel) errs++;
         if (k == v.len) btn_i = 1'b0;
      end
      check($sformatf("vec%0d trace_errors", idx), errs, 0);
      check($sformatf("vec%0d last_jump", idx), last_jump_o, v.last);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int errs;

      vecs[0] = '{len: 100, en: 1'b1, chg: 1'b1, last: 13};
      vecs[1] = '{len: 3,   en: 1'b1, chg: 1'b0, last: 13};
      vecs[2] = '{len: 500, en: 1'b1, chg: 1'b1, last: 40};
      vecs[3] = '{len: 30,  en: 1'b0, chg: 1'b0, last: 40};
      vecs[4] = '{len: 8,   en: 1'b1, chg: 1'b1, last: 1};
      vecs[5] = '{len: 9,   en: 1'b1, chg: 1'b1, last: 2};

      restart  = 1'b1;
      btn_i    = 1'b0;
      enable_i = 1'b0;
      repeat (3) tick();
      check("rst jump_dist", jump_dist_o, 0);
      check("rst charging", charging_o, 0);
      check("rst released", released_o, 0);
      check("rst last_jump", last_jump_o, 0);
      restart = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Re-press landing in cooldown must not charge; a later clean press must.
      idle(30);
      enable_i = 1'b1;
      btn_i    = 1'b1;
      errs     = 0;
      for (int k = 1; k <= 140; k++) begin
         tick();
         if (k >= 28 && k <= 106 && (jump_dist_o != 0 || charging_o || released_o)) errs++;
         if (k == 27) begin
            check("cool first released", released_o, 1);
            check("cool first last_jump", last_jump_o, 3);
         end
         if (k == 107) check("cool fresh start jump_dist", jump_dist_o, 1);
         if (k == 117) begin
            check("cool fresh released", released_o, 1);
            check("cool fresh last_jump", last_jump_o, 2);
         end
         if (k == 20)  btn_i = 1'b0;
         if (k == 25)  btn_i = 1'b1;
         if (k == 75)  btn_i = 1'b0;
         if (k == 100) btn_i = 1'b1;
         if (k == 110) btn_i = 1'b0;
      end
      check("cool quiet_errors", errs, 0);

      // restart mid-charge with the button still held.
      idle(30);
      btn_i = 1'b1;
      errs  = 0;
      for (int k = 1; k <= 140; k++) begin
         tick();
         if (k == 48) check("rstchg pre jump_dist", jump_dist_o, 6);
         if (k == 50) begin
            check("rstchg jump_dist", jump_dist_o, 0);
            check("rstchg charging", charging_o, 0);
            check("rstchg released", released_o, 0);
            restart = 1'b0;
         end
         if (k > 50 && k <= 126 && (jump_dist_o != 0 || charging_o || released_o)) errs++;
         if (k == 127) check("rstchg new start jump_dist", jump_dist_o, 1);
         if (k == 137) begin
            check("rstchg new released", released_o, 1);
            check("rstchg new last_jump", last_jump_o, 2);
         end
         if (k == 49)  restart = 1'b1;
         if (k == 100) btn_i = 1'b0;
         if (k == 120) btn_i = 1'b1;
         if (k == 130) btn_i = 1'b0;
      end
      check("rstchg quiet_errors", errs, 0);

      // enable dropped mid-charge; release lands on a step edge.
      idle(30);
      enable_i = 1'b1;
      btn_i    = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 46) check("endrop jump_dist", jump_dist_o, 5);
         if (k == 47) begin
            check("endrop released", released_o, 1);
            check("endrop cleared", jump_dist_o, 0);
            check("endrop last_jump", last_jump_o, 5);
         end
         if (k == 10) enable_i = 1'b0;
         if (k == 40) btn_i = 1'b0;
      end
      enable_i = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
